// File: rtl/anita_trigger_map_cfg.sv
// Run-time configurable ANITA L1 trigger map: routes any raw input bit to each logical output,
// with input sync, edge detect, per-output enable, pulse stretch and latched saturating scalers.
module anita_trigger_map_cfg #(
  parameter int unsigned NIN  = 32,
  parameter int unsigned NOUT = 12,
  parameter int unsigned SELW = 5,
  parameter int unsigned AW   = 4,
  parameter int unsigned STRW = 4,
  parameter int unsigned SCW  = 16
) (
  input  logic            clk_i,
  input  logic            nrst_i,
  input  logic [NIN-1:0]  trig_i,
  input  logic [NIN-1:0]  scal_i,
  input  logic            cfg_wr_i,
  input  logic [AW-1:0]   cfg_addr_i,
  input  logic [SELW-1:0] cfg_sel_i,
  input  logic            cfg_en_i,
  input  logic [STRW-1:0] stretch_i,
  input  logic            scal_latch_i,
  input  logic [AW-1:0]   scal_rd_addr_i,
  output logic [SCW-1:0]  scal_rd_data_o,
  output logic            scal_valid_o,
  output logic [NOUT-1:0] trig_o
);

  localparam int unsigned NPAD = 2 ** SELW;
  localparam logic [SCW-1:0] ScMax = '1;

  logic [NIN-1:0]  trig_s1, trig_s2, trig_s3;
  logic [NIN-1:0]  scal_s1, scal_s2, scal_s3;
  // Padded to the full select range so any select value indexes safely (unused bits read 0).
  logic [NPAD-1:0] trig_edge, scal_edge;

  logic [SELW-1:0] map_sel [NOUT];
  logic [NOUT-1:0] map_en;
  logic [STRW-1:0] cnt     [NOUT];
  logic [NOUT-1:0] trig_q;
  logic [SCW-1:0]  live    [NOUT];
  logic [SCW-1:0]  hold    [NOUT];

  logic [NOUT-1:0] wr_hit, active, sel_trig, sel_scal;
  logic [SCW-1:0]  rd_next;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      trig_s1 <= '0;
      trig_s2 <= '0;
      trig_s3 <= '0;
      scal_s1 <= '0;
      scal_s2 <= '0;
      scal_s3 <= '0;
    end else begin
      trig_s1 <= trig_i;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
      scal_s1 <= scal_i;
      scal_s2 <= scal_s1;
      scal_s3 <= scal_s2;
    end
  end

  assign trig_edge = NPAD'(trig_s2 & ~trig_s3);
  assign scal_edge = NPAD'(scal_s2 & ~scal_s3);

  always_comb begin
    wr_hit   = '0;
    active   = '0;
    sel_trig = '0;
    sel_scal = '0;
    for (int unsigned k = 0; k < NOUT; k++) begin
      wr_hit[k]   = cfg_wr_i && (32'(cfg_addr_i) == k);
      active[k]   = map_en[k] && (32'(map_sel[k]) < NIN);
      sel_trig[k] = active[k] && trig_edge[map_sel[k]];
      sel_scal[k] = active[k] && scal_edge[map_sel[k]];
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        map_sel[k] <= SELW'(k % NIN);
      end
      map_en <= '0;
    end else begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        if (wr_hit[k]) begin
          map_sel[k] <= cfg_sel_i;
          map_en[k]  <= cfg_en_i;
        end
      end
    end
  end

  // An edge (re)loads the counter; the output drops once the counter has run out.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        cnt[k] <= '0;
      end
      trig_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        if (wr_hit[k]) begin
          cnt[k]    <= '0;
          trig_q[k] <= 1'b0;
        end else if (sel_trig[k]) begin
          cnt[k]    <= stretch_i;
          trig_q[k] <= 1'b1;
        end else if (trig_q[k]) begin
          if (cnt[k] != '0) begin
            cnt[k] <= cnt[k] - 1'b1;
          end else begin
            trig_q[k] <= 1'b0;
          end
        end
      end
    end
  end

  assign trig_o = trig_q;

  // Latch snapshots the old live value; a coincident edge starts the new interval at 1.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        live[k] <= '0;
        hold[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NOUT; k++) begin
        if (scal_latch_i) begin
          hold[k] <= live[k];
        end
        if (wr_hit[k]) begin
          live[k] <= '0;
        end else if (scal_latch_i) begin
          live[k] <= SCW'(sel_scal[k]);
        end else if (sel_scal[k] && (live[k] != ScMax)) begin
          live[k] <= live[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned k = 0; k < NOUT; k++) begin
      if (32'(scal_rd_addr_i) == k) begin
        rd_next = hold[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      scal_rd_data_o <= '0;
      scal_valid_o   <= 1'b0;
    end else begin
      scal_rd_data_o <= rd_next;
      scal_valid_o   <= scal_latch_i;
    end
  end

endmodule
